// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator in front of a big-endian,
// byte-addressed memory with a combinational word read port and a clocked
// word write port. Sub-word stores are done as read-modify-write.
module mem_lsu #(
  parameter int unsigned MEMSIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_write,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEMSIZE);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t      state, state_nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [15:0] sub_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Request legality: illegal size, misalignment, or address past the memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr >= ADDR_LIMIT) req_err = 1'b1;
  end

  // Big-endian lane extraction, extension, and sub-word merge from the read word.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[31:24];
      2'd1:    ld_byte = mem_rdata[23:16];
      2'd2:    ld_byte = mem_rdata[15:8];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (size_q)
      2'b00:   ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = sub_q[7:0];
        2'd1:    merged[23:16] = sub_q[7:0];
        2'd2:    merged[15:8]  = sub_q[7:0];
        default: merged[7:0]   = sub_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = sub_q;
    end else begin
      merged[31:16] = sub_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_nxt = RESP;
          else if (!req_we)            state_nxt = LOAD;
          else if (req_size == 2'b10)  state_nxt = WRITE;
          else                         state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on acceptance; load result and merged store word per phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= 32'h0;
      off_q   <= 2'b00;
      sub_q   <= 16'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= {req_addr[31:2], 2'b00};
            off_q   <= req_addr[1:0];
            sub_q   <= req_wdata[15:0];
            word_q  <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
          end
        end
        LOAD:    rdata_q <= we_q ? 32'h0 : ld_ext;
        RMW_RD:  word_q  <= merged;
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state and data.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_raddr  = 32'h0;
    mem_write  = 1'b0;
    mem_waddr  = 32'h0;
    mem_wdata  = 32'h0;
    case (state)
      LOAD, RMW_RD: begin
        mem_read  = 1'b1;
        mem_raddr = addr_q;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = word_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: emulates the big-endian memory, keeps a byte-level
// reference model with spec latencies, and compares every cycle.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_write;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  mem_lsu #(.MEMSIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Memory emulation: combinational read, word write on the clock edge.
  logic [7:0] mem [0:1023];
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_read)
      mem_rdata = {mem[{mem_raddr[9:2], 2'd0}], mem[{mem_raddr[9:2], 2'd1}],
                   mem[{mem_raddr[9:2], 2'd2}], mem[{mem_raddr[9:2], 2'd3}]};
  end
  always @(posedge clk) begin
    if (mem_write) begin
      mem[{mem_waddr[9:2], 2'd0}] <= mem_wdata[31:24];
      mem[{mem_waddr[9:2], 2'd1}] <= mem_wdata[23:16];
      mem[{mem_waddr[9:2], 2'd2}] <= mem_wdata[15:8];
      mem[{mem_waddr[9:2], 2'd3}] <= mem_wdata[7:0];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0]  ref_mem [0:1023];
  bit          pend = 0;
  int          age = 0;
  int          m_lat, m_rd_age, m_wr_age;
  bit          m_we, m_err;
  logic [31:0] m_a, m_rdata, m_word;
  logic [7:0]  m_bytes [0:3];
  int          n_acc = 0, n_resp = 0;
  int          cyc = 0;
  int          acc_hist[$];
  logic [31:0] last_rdata, last_wdata;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Derive the expected transaction from the request using the memory image.
  task automatic model_accept();
    int a;
    logic [1:0] o;
    logic [7:0] b;
    logic [15:0] h;
    o = req_addr[1:0];
    m_a = req_addr & 32'hFFFF_FFFC;
    m_we = req_we;
    m_err = (req_size == 2'b11) || (req_size == 2'b01 && o[0]) ||
            (req_size == 2'b10 && o != 2'b00) || (req_addr >= 32'd1024);
    m_rdata = 32'h0;
    m_word = 32'h0;
    m_rd_age = 0;
    m_wr_age = 0;
    if (m_err) begin
      m_lat = 1;
    end else begin
      a = int'(m_a);
      for (int i = 0; i < 4; i++) m_bytes[i] = ref_mem[a + i];
      if (!req_we) begin
        m_lat = 2;
        m_rd_age = 1;
        b = m_bytes[o];
        h = {m_bytes[o], m_bytes[o | 2'd1]};
        if (req_size == 2'b10)
          m_rdata = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        else if (req_size == 2'b01)
          m_rdata = (req_signed && h[15]) ? (32'hFFFF0000 | {16'h0, h}) : {16'h0, h};
        else
          m_rdata = (req_signed && b[7]) ? (32'hFFFFFF00 | {24'h0, b}) : {24'h0, b};
      end else begin
        if (req_size == 2'b10) begin
          m_lat = 2;
          m_wr_age = 1;
          m_bytes[0] = req_wdata[31:24];
          m_bytes[1] = req_wdata[23:16];
          m_bytes[2] = req_wdata[15:8];
          m_bytes[3] = req_wdata[7:0];
        end else begin
          m_lat = 3;
          m_rd_age = 1;
          m_wr_age = 2;
          if (req_size == 2'b00) begin
            m_bytes[o] = req_wdata[7:0];
          end else begin
            m_bytes[o] = req_wdata[15:8];
            m_bytes[o | 2'd1] = req_wdata[7:0];
          end
        end
        m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      end
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    bit e_rv, e_rd, e_wr;
    if (rst) begin
      pend = 0;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
      chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
      chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
      chk("rst_mem_raddr", mem_raddr, 32'h0);
      chk("rst_mem_waddr", mem_waddr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
    end else begin
      if (pend) age++;
      e_rv = pend && (age == m_lat);
      e_rd = pend && (age == m_rd_age);
      e_wr = pend && (age == m_wr_age);
      chk("req_ready", {31'h0, req_ready}, {31'h0, !pend});
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, e_rv});
      chk("resp_rdata", resp_rdata, e_rv ? m_rdata : 32'h0);
      chk("resp_err", {31'h0, resp_err}, {31'h0, e_rv && m_err});
      chk("mem_read", {31'h0, mem_read}, {31'h0, e_rd});
      chk("mem_raddr", mem_raddr, e_rd ? m_a : 32'h0);
      chk("mem_write", {31'h0, mem_write}, {31'h0, e_wr});
      chk("mem_waddr", mem_waddr, e_wr ? m_a : 32'h0);
      chk("mem_wdata", mem_wdata, e_wr ? m_word : 32'h0);
      if (mem_write) last_wdata = mem_wdata;
      if (e_rv) begin
        if (m_we && !m_err)
          for (int i = 0; i < 4; i++) ref_mem[int'(m_a) + i] = m_bytes[i];
        last_rdata = resp_rdata;
        last_err = resp_err;
        n_resp++;
        pend = 0;
      end else if (!pend && req_valid) begin
        model_accept();
        pend = 1;
        age = 0;
        n_acc++;
        acc_hist.push_back(cyc);
      end
    end
  end

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event expected one within budget", nm);
  endtask

  task automatic wait_acc(input int a0);
    int k = 0;
    while (n_acc == a0 && k < 40) begin @(negedge clk); #1; k++; end
    if (n_acc == a0) timeout("accept_timeout");
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd, input bit keep,
                      output logic [31:0] rd, output logic er);
    int a0, r0, k;
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk); #2;
    req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    wait_acc(a0);
    @(posedge clk); #2;
    if (!keep) req_valid = 1'b0;
    k = 0;
    while (n_resp == r0 && k < 40) begin @(negedge clk); #1; k++; end
    if (n_resp == r0) timeout("resp_timeout");
    rd = last_rdata;
    er = last_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          a0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[0] = 8'h80; mem[1] = 8'h7F; mem[2] = 8'h12; mem[3] = 8'h34;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    xact(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 0, rd, er);
    chk("ld_word0", rd, 32'h807F1234);
    chk("ld_word0_err", {31'h0, er}, 32'h0);
    xact(1'b0, 2'b00, 1'b1, 32'd0, 32'h0, 0, rd, er);
    chk("ld_sbyte0", rd, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'd1, 32'h0, 0, rd, er);
    chk("ld_ubyte1", rd, 32'h0000007F);
    xact(1'b0, 2'b01, 1'b1, 32'd2, 32'h0, 0, rd, er);
    chk("ld_shalf2", rd, 32'h00001234);
    xact(1'b0, 2'b01, 1'b1, 32'd0, 32'h0, 0, rd, er);
    chk("ld_shalf0", rd, 32'hFFFF807F);
    xact(1'b0, 2'b01, 1'b0, 32'd0, 32'h0, 0, rd, er);
    chk("ld_uhalf0", rd, 32'h0000807F);

    xact(1'b1, 2'b00, 1'b0, 32'd1, 32'hAAAAAA55, 0, rd, er);
    chk("st_byte1_wdata", last_wdata, 32'h80551234);
    chk("st_byte1_rdata", rd, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 0, rd, er);
    chk("ld_after_stb", rd, 32'h80551234);
    xact(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000BEEF, 0, rd, er);
    xact(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 0, rd, er);
    chk("ld_after_sth", rd, 32'h8055BEEF);

    xact(1'b1, 2'b01, 1'b0, 32'd3, 32'h1234, 0, rd, er);
    chk("err_half3", {31'h0, er}, 32'h1);
    xact(1'b1, 2'b10, 1'b0, 32'd2, 32'h1234, 0, rd, er);
    chk("err_word2", {31'h0, er}, 32'h1);
    xact(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 0, rd, er);
    chk("err_size3", {31'h0, er}, 32'h1);
    chk("err_size3_rdata", rd, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 0, rd, er);
    chk("err_range", {31'h0, er}, 32'h1);

    xact(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 1, rd, er);
    xact(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 0, rd, er);
    chk("ld_word8", rd, 32'hDEADBEEF);
    chk("b2b_accept_gap", acc_hist[$] - acc_hist[$-1], 32'd3);
    chk("mem8_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);

    a0 = n_acc;
    @(posedge clk); #2;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd5; req_wdata = 32'h99;
    req_valid = 1'b1;
    wait_acc(a0);
    @(posedge clk); #2;
    chk("rmw_rd_mem_read", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("async_mem_read", {31'h0, mem_read}, 32'h0);
    chk("async_mem_raddr", mem_raddr, 32'h0);
    chk("async_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 0, rd, er);
    chk("ld_after_abort", rd, 32'h11223344);
    chk("mem5_unchanged", {24'h0, mem[5]}, 32'h22);
    xact(1'b1, 2'b00, 1'b0, 32'd7, 32'h00000066, 0, rd, er);
    xact(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 0, rd, er);
    chk("ld_after_recover", rd, 32'h11223366);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
